// File: rtl/slow_transmitter3.sv
// Queued serial frame transmitter: FIFO of payloads, each sent as start bit,
// payload MSB first, CRC-8 (poly 0x07) MSB first, stop bit, then an idle-high gap.
module slow_transmitter3 #(
  parameter int PAYLOAD_W       = 128,
  parameter int FIFO_DEPTH      = 4,
  parameter int BIT_CLK_DIVIDER = 5,
  parameter int GAP_BITS        = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [PAYLOAD_W-1:0]        payload_i,
  input  logic                        frame_tick_i,
  input  logic                        clear_overflow_i,
  output logic                        serial_o,
  output logic                        idle_o,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level_o,
  output logic                        overflow_o,
  output logic                        frame_done_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int DIV_W = $clog2(BIT_CLK_DIVIDER);
  localparam int CNT_W = $clog2(PAYLOAD_W + GAP_BITS + 8);

  typedef enum logic [2:0] {IDLE, START, DATA, CRC, STOP, GAP} state_t;

  state_t               state;
  state_t               next_state;

  logic [PAYLOAD_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [LVL_W-1:0]     level;
  logic                 full;
  logic                 has_data;
  logic                 push;
  logic                 pop;

  logic [DIV_W-1:0]     div_cnt;
  logic [CNT_W-1:0]     bit_cnt;
  logic                 bit_end;
  logic [PAYLOAD_W-1:0] shreg;
  logic [7:0]           crc;
  logic                 crc_fb;
  logic [7:0]           crc_next;
  logic                 line_bit;
  logic                 done_pulse;

  assign full     = (level == LVL_W'(FIFO_DEPTH));
  assign has_data = (level != '0);
  assign push     = frame_tick_i && !full;
  assign bit_end  = (div_cnt == DIV_W'(BIT_CLK_DIVIDER - 1));
  assign crc_fb   = crc[7] ^ shreg[PAYLOAD_W-1];
  assign crc_next = {crc[6:0], 1'b0} ^ (crc_fb ? 8'h07 : 8'h00);

  assign fifo_level_o = level;
  assign idle_o       = (state == IDLE) && !has_data;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= payload_i;
    end
  end

  // A push into a full FIFO is dropped even when a pop frees a slot this cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        level <= level + LVL_W'(1);
      end else if (!push && pop) begin
        level <= level - LVL_W'(1);
      end
      if (frame_tick_i && full) begin
        overflow_o <= 1'b1;
      end else if (clear_overflow_i) begin
        overflow_o <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    pop        = 1'b0;
    line_bit   = 1'b1;
    done_pulse = 1'b0;
    case (state)
      IDLE: begin
        if (has_data) begin
          pop        = 1'b1;
          next_state = START;
        end
      end
      START: begin
        line_bit = 1'b0;
        if (bit_end) begin
          next_state = DATA;
        end
      end
      DATA: begin
        line_bit = shreg[PAYLOAD_W-1];
        if (bit_end && bit_cnt == CNT_W'(PAYLOAD_W - 1)) begin
          next_state = CRC;
        end
      end
      CRC: begin
        line_bit = crc[7];
        if (bit_end && bit_cnt == CNT_W'(7)) begin
          next_state = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          done_pulse = 1'b1;
          next_state = GAP;
        end
      end
      GAP: begin
        // Chain straight into the next queued frame so no idle cycle is inserted.
        if (bit_end && bit_cnt == CNT_W'(GAP_BITS - 1)) begin
          if (has_data) begin
            pop        = 1'b1;
            next_state = START;
          end else begin
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // serial_o and frame_done_o both lag the state by one cycle, keeping them aligned.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt      <= '0;
      bit_cnt      <= '0;
      shreg        <= '0;
      crc          <= '0;
      serial_o     <= 1'b1;
      frame_done_o <= 1'b0;
    end else begin
      serial_o     <= line_bit;
      frame_done_o <= done_pulse;
      if (state == IDLE || bit_end) begin
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
      if (next_state != state) begin
        bit_cnt <= '0;
      end else if (bit_end) begin
        bit_cnt <= bit_cnt + CNT_W'(1);
      end
      if (pop) begin
        shreg <= mem[rd_ptr];
        crc   <= '0;
      end else if (bit_end) begin
        if (state == DATA) begin
          shreg <= {shreg[PAYLOAD_W-2:0], 1'b0};
          crc   <= crc_next;
        end else if (state == CRC) begin
          crc <= {crc[6:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: tb/tb_slow_transmitter3.sv
// Self-checking bench for slow_transmitter3: serial decoder plus a timeline
// model of the queue, directed vectors, corner sequences and random traffic.
module tb_slow_transmitter3;

  localparam int PW         = 32;
  localparam int DEPTH      = 4;
  localparam int DIV        = 5;
  localparam int GAP        = 2;
  localparam int FRAME_BITS = PW + 10;
  localparam int FRAME_CYC  = FRAME_BITS * DIV;
  localparam int SLOT_CYC   = FRAME_CYC + GAP * DIV;

  typedef struct packed {
    logic [PW-1:0] payload;
    logic [7:0]    crc;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [PW-1:0] payload = '0;
  logic          frame_tick = 1'b0;
  logic          clear_overflow = 1'b0;
  logic          serial;
  logic          idle;
  logic [2:0]    fifo_level;
  logic          overflow;
  logic          frame_done;

  slow_transmitter3 #(
    .PAYLOAD_W(PW), .FIFO_DEPTH(DEPTH), .BIT_CLK_DIVIDER(DIV), .GAP_BITS(GAP)
  ) dut (
    .clk(clk), .reset(reset), .payload_i(payload), .frame_tick_i(frame_tick),
    .clear_overflow_i(clear_overflow), .serial_o(serial), .idle_o(idle),
    .fifo_level_o(fifo_level), .overflow_o(overflow), .frame_done_o(frame_done)
  );

  always #5 clk = ~clk;

  int checks_total = 0;
  int checks_passed = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks_total++;
    if (actual === expected) checks_passed++;
    else $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", name, actual, expected);
  endtask

  function automatic logic [7:0] crc8(input logic [PW-1:0] d);
    logic [7:0] c;
    c = '0;
    for (int i = PW - 1; i >= 0; i--) begin
      c = c ^ {d[i], 7'b0};
      c = {c[6:0], 1'b0} ^ (c[7] ? 8'h07 : 8'h00);
    end
    return c;
  endfunction

  // Reference model: queue of waiting payloads and the edge at which the line is next free.
  logic [PW-1:0] mq[$];
  logic [PW-1:0] exp_frames[$];
  longint        m_t = 0;
  longint        m_free_at = 0;
  logic          m_ovf = 1'b0;
  bit            m_full;
  bit            m_pop;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      exp_frames.delete();
      m_free_at = 0;
      m_ovf = 1'b0;
    end else begin
      m_t++;
      m_full = (mq.size() == DEPTH);
      m_pop  = (mq.size() != 0) && (m_t >= m_free_at);
      if (frame_tick && m_full) m_ovf = 1'b1;
      else if (clear_overflow) m_ovf = 1'b0;
      if (m_pop) begin
        exp_frames.push_back(mq.pop_front());
        m_free_at = m_t + SLOT_CYC;
      end
      if (frame_tick && !m_full) mq.push_back(payload);
    end
  end

  function automatic bit modelIdle();
    return (mq.size() == 0) && (m_t >= m_free_at);
  endfunction

  // Line decoder: captures every cycle of a frame from its falling start edge.
  longint                 cycle_count = 0;
  logic [FRAME_CYC-1:0]   samples;
  bit                     in_frame = 0;
  int                     cyc = 0;
  int                     dones = 0;
  int                     done_at = -1;
  longint                 start_cyc = 0;
  int                     frames_seen = 0;
  logic [PW-1:0]          last_payload = '0;
  logic [7:0]             last_crc = '0;
  longint                 last_start = 0;

  always @(posedge clk) cycle_count++;

  task automatic finishFrame();
    logic [FRAME_BITS-1:0] bits;
    bit consistent;
    logic [PW-1:0] exp_p;
    consistent = 1;
    for (int b = 0; b < FRAME_BITS; b++) begin
      bits[FRAME_BITS-1-b] = samples[b*DIV];
      for (int k = 1; k < DIV; k++)
        if (samples[b*DIV+k] !== samples[b*DIV]) consistent = 0;
    end
    checkOutput("bit_width", consistent, 1);
    checkOutput("start_bit", bits[FRAME_BITS-1], 0);
    checkOutput("stop_bit", bits[0], 1);
    checkOutput("frame_done_count", dones, 1);
    checkOutput("frame_done_pos", done_at, FRAME_CYC - 1);
    checkOutput("frame_expected", exp_frames.size() > 0, 1);
    if (exp_frames.size() > 0) begin
      exp_p = exp_frames.pop_front();
      checkOutput("frame_payload", bits[FRAME_BITS-2 -: PW], exp_p);
      checkOutput("frame_crc", bits[8:1], crc8(exp_p));
    end
    last_payload = bits[FRAME_BITS-2 -: PW];
    last_crc     = bits[8:1];
    last_start   = start_cyc;
    frames_seen++;
  endtask

  always @(negedge clk) begin
    if (reset) begin
      in_frame = 0;
    end else begin
      if (!in_frame && serial === 1'b0) begin
        in_frame = 1; cyc = 0; dones = 0; done_at = -1; start_cyc = cycle_count;
      end
      if (in_frame) begin
        samples[cyc] = serial;
        if (frame_done === 1'b1) begin dones++; done_at = cyc; end
        cyc++;
        if (cyc == FRAME_CYC) begin
          in_frame = 0;
          finishFrame();
        end
      end else begin
        checkOutput("frame_done_idle", frame_done, 0);
      end
      checkOutput("fifo_level", fifo_level, mq.size());
      checkOutput("overflow", overflow, m_ovf);
      checkOutput("idle", idle, modelIdle());
    end
  end

  task automatic applyStimulus(input logic [PW-1:0] p, input logic t, input logic c);
    payload = p; frame_tick = t; clear_overflow = c;
    @(negedge clk);
  endtask

  task automatic waitFrames(input int n, input int budget);
    int target;
    int k;
    target = frames_seen + n;
    k = 0;
    while (frames_seen < target && k < budget) begin @(negedge clk); k++; end
    checkOutput("frame_arrival", frames_seen >= target, 1);
  endtask

  task automatic waitModelIdle(input int budget);
    int k;
    k = 0;
    while (!modelIdle() && k < budget) begin @(negedge clk); k++; end
    checkOutput("reach_idle", modelIdle(), 1);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t          vecs[6];
    logic [PW-1:0] burst[6];
    logic [PW-1:0] fresh;
    longint        s1;

    vecs[0] = '{32'h00000000, 8'h00};
    vecs[1] = '{32'hFFFFFFFF, 8'hDE};
    vecs[2] = '{32'h80000000, 8'h31};
    vecs[3] = '{32'h00000100, 8'h15};
    vecs[4] = '{32'h000000FF, 8'hF3};
    vecs[5] = '{32'h01000000, 8'h16};

    // Ticks while reset is held must be ignored.
    applyStimulus(32'hDEADBEEF, 1, 0);
    applyStimulus(32'h0BADF00D, 1, 0);
    checkOutput("rst_serial", serial, 1);
    checkOutput("rst_level", fifo_level, 0);
    checkOutput("rst_idle", idle, 1);
    checkOutput("rst_overflow", overflow, 0);
    checkOutput("rst_frame_done", frame_done, 0);
    reset = 1'b0;
    applyStimulus('0, 0, 0);
    applyStimulus('0, 0, 0);
    checkOutput("post_rst_level", fifo_level, 0);
    checkOutput("post_rst_serial", serial, 1);

    // Single frame: start latency is two edges after the sampling edge.
    applyStimulus(32'h00000001, 1, 0);
    checkOutput("lat_e0_serial", serial, 1);
    checkOutput("lat_e0_level", fifo_level, 1);
    applyStimulus('0, 0, 0);
    checkOutput("lat_e1_serial", serial, 1);
    checkOutput("lat_e1_level", fifo_level, 0);
    applyStimulus('0, 0, 0);
    checkOutput("lat_e2_serial", serial, 0);
    waitFrames(1, FRAME_CYC + 20);
    checkOutput("one_payload", last_payload, 32'h00000001);
    checkOutput("one_crc", last_crc, 8'h07);
    waitModelIdle(SLOT_CYC);

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].payload, 1, 0);
      applyStimulus('0, 0, 0);
      waitFrames(1, FRAME_CYC + 20);
      checkOutput("vec_payload", last_payload, vecs[i].payload);
      checkOutput("vec_crc", last_crc, vecs[i].crc);
      waitModelIdle(SLOT_CYC);
    end

    // Back-to-back frames: gap between stop end and next start is GAP bit periods.
    applyStimulus(32'h00000000, 1, 0);
    applyStimulus(32'hFFFFFFFF, 1, 0);
    applyStimulus('0, 0, 0);
    waitFrames(1, FRAME_CYC + 20);
    s1 = last_start;
    checkOutput("b2b_crc0", last_crc, 8'h00);
    waitFrames(1, SLOT_CYC + 20);
    checkOutput("b2b_crc1", last_crc, 8'hDE);
    checkOutput("b2b_spacing", last_start - s1, SLOT_CYC);
    waitModelIdle(SLOT_CYC);

    // Burst of six pushes: one pops, four queue, the sixth is dropped.
    for (int k = 0; k < 6; k++) begin
      burst[k] = $urandom;
      applyStimulus(burst[k], 1, 0);
    end
    checkOutput("burst_level", fifo_level, 4);
    checkOutput("burst_overflow", overflow, 1);
    applyStimulus($urandom, 1, 1);
    checkOutput("clear_with_drop", overflow, 1);
    checkOutput("clear_with_drop_level", fifo_level, 4);
    applyStimulus('0, 0, 1);
    checkOutput("clear_alone", overflow, 0);
    applyStimulus('0, 0, 0);
    waitFrames(5, 5 * SLOT_CYC + 50);
    checkOutput("burst_last_payload", last_payload, burst[4]);
    waitModelIdle(SLOT_CYC);

    // Reset in mid-frame aborts it and flushes the queue.
    applyStimulus(32'h00000000, 1, 0);
    applyStimulus(32'h12345678, 1, 0);
    applyStimulus('0, 0, 0);
    repeat (99) @(negedge clk);
    checkOutput("pre_reset_serial", serial, 0);
    checkOutput("pre_reset_level", fifo_level, 1);
    #2 reset = 1'b1;
    #1;
    checkOutput("abort_serial", serial, 1);
    checkOutput("abort_level", fifo_level, 0);
    checkOutput("abort_idle", idle, 1);
    checkOutput("abort_overflow", overflow, 0);
    checkOutput("abort_frame_done", frame_done, 0);
    applyStimulus(32'hFFFF0000, 1, 0);
    applyStimulus(32'hFFFF0000, 1, 0);
    reset = 1'b0;
    applyStimulus('0, 0, 0);
    applyStimulus('0, 0, 0);
    checkOutput("resume_level", fifo_level, 0);
    checkOutput("resume_serial", serial, 1);
    fresh = 32'hC3C3A55A;
    applyStimulus(fresh, 1, 0);
    applyStimulus('0, 0, 0);
    waitFrames(1, FRAME_CYC + 20);
    checkOutput("fresh_payload", last_payload, fresh);
    checkOutput("fresh_crc", last_crc, crc8(fresh));
    waitModelIdle(SLOT_CYC);

    // Random traffic with occasional overflow clears; the model tracks everything.
    for (int c = 0; c < 3000; c++) begin
      applyStimulus($urandom, $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 2);
    end
    applyStimulus('0, 0, 0);
    waitModelIdle((DEPTH + 2) * SLOT_CYC);
    repeat (5) @(negedge clk);
    checkOutput("all_frames_seen", exp_frames.size(), 0);
    checkOutput("final_idle", idle, 1);
    checkOutput("final_serial", serial, 1);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/slow_transmitter3.md
SLOW_TRANSMITTER3 -- requirements
Module: slow_transmitter3

Interface
REQ-001 SHALL have parameter PAYLOAD_W, default 128, payload width in bits (multiple of 8, >=8).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, number of queued payloads (power of 2, >=2).
REQ-003 SHALL have parameter BIT_CLK_DIVIDER, default 5, clock cycles per serial bit (>=2).
REQ-004 SHALL have parameter GAP_BITS, default 2, minimum idle-high bit periods between frames (>=1).
REQ-005 SHALL have port clk  input  1  clock; all state on rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port payload_i  input  PAYLOAD_W  data to transmit.
REQ-008 SHALL have port frame_tick_i  input  1  push payload_i into FIFO when high at a rising edge.
REQ-009 SHALL have port clear_overflow_i  input  1  clears overflow_o.
REQ-010 SHALL have port serial_o  output  1  serial line, idle high.
REQ-011 SHALL have port idle_o  output  1  high when FSM in IDLE and FIFO empty.
REQ-012 SHALL have port fifo_level_o  output  $clog2(FIFO_DEPTH)+1  occupied FIFO entries.
REQ-013 SHALL have port overflow_o  output  1  sticky flag: a push was dropped.
REQ-014 SHALL have port frame_done_o  output  1  one-cycle pulse on the last cycle of each stop bit.

Function
REQ-015 SHALL send frame = start bit 0, payload MSB first, CRC-8 MSB first, stop bit 1.
REQ-016 SHALL compute CRC-8 with poly 0x07, init 0x00, no reflection, no final XOR, over payload MSB first.
REQ-017 SHALL hold every bit for exactly BIT_CLK_DIVIDER cycles; frame length (PAYLOAD_W+10)*BIT_CLK_DIVIDER cycles.
REQ-018 SHALL register serial_o (no combinational path from any input).
REQ-019 SHALL implement FSM states IDLE, START, DATA, CRC, STOP, GAP.
REQ-020 SHALL transition IDLE->START when FIFO non-empty, popping the head entry in the same cycle.
REQ-021 SHALL transition START->DATA->CRC->STOP at bit-period boundaries after 1, PAYLOAD_W and 8 bits.
REQ-022 SHALL transition STOP->GAP, then GAP->IDLE after GAP_BITS bit periods with serial_o high.
REQ-023 SHALL drive serial_o low on the 2nd rising edge after the edge sampling frame_tick_i when FIFO empty and FSM in IDLE.
REQ-024 SHALL accept a push whenever fifo_level_o < FIFO_DEPTH.
REQ-025 SHALL drop the push when full and set overflow_o, even if a pop occurs in the same cycle.
REQ-026 SHALL, on simultaneous push and pop with FIFO not full, leave fifo_level_o unchanged.
REQ-027 SHALL wrap FIFO read/write pointers modulo FIFO_DEPTH.
REQ-028 SHALL clear overflow_o on clear_overflow_i; a same-cycle drop keeps it set.
REQ-029 SHALL capture the payload at pop; later FIFO changes do not affect the frame in flight.
REQ-030 SHALL start the next queued frame immediately after GAP ends, without extra idle cycles.

Reset
REQ-031 SHALL, on reset asserted, immediately force serial_o=1, idle_o=1, fifo_level_o=0, overflow_o=0, frame_done_o=0, FSM=IDLE, FIFO empty.
REQ-032 SHALL abort a frame in progress on reset; no partial frame resumes after release.
REQ-033 SHALL ignore frame_tick_i on the first rising edge while reset is high and on all edges during reset.

Verification (bench parameters: PAYLOAD_W=32, FIFO_DEPTH=4, BIT_CLK_DIVIDER=5, GAP_BITS=2)
REQ-034 SHALL verify: push 0x00000001 -> start bit, 31 zeros then 1, CRC 0x07 (00000111), stop 1, 210 cycles total, frame_done_o single pulse.
REQ-035 SHALL verify: push 0x00000000 and 0xFFFFFFFF back to back -> second start bit exactly 10 cycles after first stop bit ends; CRCs 0x00 and 0xDE.
REQ-036 SHALL verify: 6 pushes in consecutive cycles while idle -> first pops, 4 queued, 6th dropped, overflow_o=1, fifo_level_o=4.
REQ-037 SHALL verify: clear_overflow_i pulse -> overflow_o=0 next cycle; with simultaneous drop -> stays 1.
REQ-038 SHALL verify: reset asserted at cycle 100 of a frame -> serial_o=1 before next edge, fifo_level_o=0; new push after release sends a complete fresh frame.
REQ-039 SHALL verify: random payloads and pushes -> decoded bitstream and CRC match a reference model; idle_o=1 only when FIFO empty and line idle.
